// File: rtl/bf_weight_loader.sv
// bf_weight_loader: double-buffered beam-weight bank for the 8-channel
// beamformer. The host fills a shadow bank; a commit copies it to the
// active bank on the next prescaler frame boundary.
//
// Ports:
//   clock, reset       synchronous active-high reset
//   wr_valid/wr_ready  shadow write handshake
//   wr_sel             0 cos_1, 1 sin_1, 2 cos_2, 3 sin_2
//   wr_ch, wr_bcast    target channel, or all 8 when wr_bcast
//   wr_data            5-bit two's-complement weight
//   commit_req         request shadow-to-active copy
//   busy               commit pending
//   commit_done        pulse in the first cycle new weights are visible
//   w_cos_1..w_sin_2   active bank, channel c at [c]
module bf_weight_loader #(
   parameter int         FRAME_LEN = 8,
   parameter logic [4:0] RST_COS   = 5'd15
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            wr_valid,
   output logic            wr_ready,
   input  logic [1:0]      wr_sel,
   input  logic [2:0]      wr_ch,
   input  logic            wr_bcast,
   input  logic [4:0]      wr_data,
   input  logic            commit_req,
   output logic            busy,
   output logic            commit_done,
   output logic [7:0][4:0] w_cos_1,
   output logic [7:0][4:0] w_sin_1,
   output logic [7:0][4:0] w_cos_2,
   output logic [7:0][4:0] w_sin_2
);

   localparam int CW = $clog2(FRAME_LEN);

   typedef enum logic {
      IDLE,
      PENDING
   } state_t;

   typedef logic [3:0][7:0][4:0] bank_t;

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  frame_cnt;
   logic           frame_end;
   logic           swap;
   logic           wr_fire;
   bank_t          shadow;
   bank_t          active;

   // Odd selects are sin arrays (reset 0), even selects are cos arrays.
   function automatic bank_t bank_default();
      bank_t b;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) begin
            b[s][c] = (s % 2 == 1) ? 5'd0 : RST_COS;
         end
      end
      return b;
   endfunction

   assign frame_end = (frame_cnt == CW'(FRAME_LEN - 1));

   always_comb begin
      state_nxt = state;
      wr_ready  = 1'b0;
      busy      = 1'b0;
      swap      = 1'b0;
      unique case (state)
         IDLE: begin
            wr_ready = 1'b1;
            if (commit_req) begin
               state_nxt = PENDING;
            end
         end
         PENDING: begin
            busy = 1'b1;
            if (frame_end) begin
               swap      = 1'b1;
               state_nxt = IDLE;
            end
         end
      endcase
      // Reset forces the handshake to its idle look immediately.
      if (reset) begin
         wr_ready = 1'b1;
         busy     = 1'b0;
      end
   end

   assign wr_fire = wr_valid & wr_ready & ~reset;

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         frame_cnt <= '0;
      end else begin
         state     <= state_nxt;
         frame_cnt <= frame_cnt + CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         commit_done <= 1'b0;
         shadow      <= bank_default();
         active      <= bank_default();
      end else begin
         commit_done <= swap;
         if (swap) begin
            active <= shadow;
         end
         if (wr_fire) begin
            for (int c = 0; c < 8; c++) begin
               if (wr_bcast || wr_ch == 3'(c)) begin
                  shadow[wr_sel][c] <= wr_data;
               end
            end
         end
      end
   end

   assign w_cos_1 = active[0];
   assign w_sin_1 = active[1];
   assign w_cos_2 = active[2];
   assign w_sin_2 = active[3];

endmodule

// File: tb/tb_bf_weight_loader.sv
// tb_bf_weight_loader: directed plus randomized checks of bf_weight_loader
// against a frame-latency model of the weight banks.
module tb_bf_weight_loader;

   localparam int FL = 8;
   localparam logic [4:0] RC = 5'd15;

   logic            clock;
   logic            reset;
   logic            wr_valid;
   logic            wr_ready;
   logic [1:0]      wr_sel;
   logic [2:0]      wr_ch;
   logic            wr_bcast;
   logic [4:0]      wr_data;
   logic            commit_req;
   logic            busy;
   logic            commit_done;
   logic [7:0][4:0] w_cos_1;
   logic [7:0][4:0] w_sin_1;
   logic [7:0][4:0] w_cos_2;
   logic [7:0][4:0] w_sin_2;

   bf_weight_loader #(.FRAME_LEN(FL), .RST_COS(RC)) dut (
      .clock(clock),
      .reset(reset),
      .wr_valid(wr_valid),
      .wr_ready(wr_ready),
      .wr_sel(wr_sel),
      .wr_ch(wr_ch),
      .wr_bcast(wr_bcast),
      .wr_data(wr_data),
      .commit_req(commit_req),
      .busy(busy),
      .commit_done(commit_done),
      .w_cos_1(w_cos_1),
      .w_sin_1(w_sin_1),
      .w_cos_2(w_cos_2),
      .w_sin_2(w_sin_2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int ntests = 0;
   int nfail  = 0;
   bit chk_en = 1'b0;

   // Model: shadow/active arrays, frame position, pending swap cycle.
   logic [4:0] m_sh  [4][8];
   logic [4:0] m_act [4][8];
   int         m_fc;
   int         m_cyc;
   int         m_swap_at;
   bit         m_pend;
   bit         m_done;

   function automatic void chk(string name, logic [63:0] act,
                               logic [63:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   function automatic void m_defaults();
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) begin
            m_sh[s][c]  = (s % 2 == 1) ? 5'd0 : RC;
            m_act[s][c] = (s % 2 == 1) ? 5'd0 : RC;
         end
      end
   endfunction

   function automatic logic [39:0] mpack(int s);
      logic [39:0] r;
      for (int c = 0; c < 8; c++) r[c*5 +: 5] = m_act[s][c];
      return r;
   endfunction

   // Applied at each rising edge with the inputs that edge samples.
   function automatic void model_edge();
      if (reset) begin
         m_defaults();
         m_fc   = 0;
         m_pend = 0;
         m_done = 0;
      end else begin
         m_done = 0;
         if (m_pend) begin
            if (m_cyc == m_swap_at) begin
               m_act  = m_sh;
               m_pend = 0;
               m_done = 1;
            end
         end else begin
            if (wr_valid) begin
               for (int c = 0; c < 8; c++) begin
                  if (wr_bcast || int'(wr_ch) == c)
                     m_sh[wr_sel][c] = wr_data;
               end
            end
            if (commit_req) begin
               m_pend    = 1;
               m_swap_at = m_cyc + ((m_fc < FL - 1) ? (FL - 1 - m_fc) : FL);
            end
         end
         m_fc = (m_fc + 1) % FL;
      end
      m_cyc++;
   endfunction

   always @(negedge clock) begin
      if (chk_en) begin
         chk("wr_ready", 64'(wr_ready), 64'(reset || !m_pend));
         chk("busy", 64'(busy), 64'(!reset && m_pend));
         chk("commit_done", 64'(commit_done), 64'(m_done));
         chk("w_cos_1", 64'(w_cos_1), 64'(mpack(0)));
         chk("w_sin_1", 64'(w_sin_1), 64'(mpack(1)));
         chk("w_cos_2", 64'(w_cos_2), 64'(mpack(2)));
         chk("w_sin_2", 64'(w_sin_2), 64'(mpack(3)));
      end
   end

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
   endtask

   task automatic wait_fc(input int k);
      for (int i = 0; i < 2 * FL && m_fc != k; i++) step();
   endtask

   task automatic commit();
      commit_req = 1'b1;
      step();
      commit_req = 1'b0;
   endtask

   // Edges after the sampling edge until commit_done is seen.
   task automatic wait_done(output int n);
      n = -1;
      for (int i = 1; i <= 3 * FL; i++) begin
         step();
         if (commit_done === 1'b1) begin
            n = i;
            break;
         end
      end
      if (n < 0) begin
         nfail++;
         ntests++;
         $display("FAIL commit_timeout: got none expected commit_done");
      end
   endtask

   task automatic wr(input logic [1:0] s, input logic [2:0] c,
                     input logic b, input logic [4:0] d);
      wr_valid = 1'b1;
      wr_sel   = s;
      wr_ch    = c;
      wr_bcast = b;
      wr_data  = d;
      step();
      wr_valid = 1'b0;
      wr_bcast = 1'b0;
   endtask

   initial begin
      int n;
      logic [39:0] exp40;
      reset      = 1'b1;
      wr_valid   = 1'b0;
      wr_sel     = '0;
      wr_ch      = '0;
      wr_bcast   = 1'b0;
      wr_data    = '0;
      commit_req = 1'b0;
      m_cyc      = 0;
      m_swap_at  = -1;
      step();
      chk_en = 1'b1;
      step();
      reset = 1'b0;

      chk("rst_cos_1", 64'(w_cos_1), 64'({8{5'd15}}));
      chk("rst_sin_1", 64'(w_sin_1), 64'd0);
      chk("rst_cos_2", 64'(w_cos_2), 64'({8{5'd15}}));
      chk("rst_sin_2", 64'(w_sin_2), 64'd0);
      chk("rst_ready", 64'(wr_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      repeat (100) step();
      chk("idle100_cos_1", 64'(w_cos_1), 64'({8{5'd15}}));

      // Shadow isolation, then commit at frame position 2.
      wr(2'd1, 3'd3, 1'b0, 5'b11001);
      step();
      chk("shadow_iso", 64'(w_sin_1), 64'd0);
      wait_fc(2);
      commit();
      wait_done(n);
      chk("lat_k2", 64'(n), 64'd5);
      exp40 = '0;
      exp40[15 +: 5] = 5'b11001;
      chk("commit_sin_1", 64'(w_sin_1), 64'(exp40));
      chk("commit_cos_1", 64'(w_cos_1), 64'({8{5'd15}}));
      step();
      chk("done_one_cycle", 64'(commit_done), 64'd0);

      // Boundary latencies.
      wait_fc(7);
      commit();
      wait_done(n);
      chk("lat_k7", 64'(n), 64'd8);
      wait_fc(6);
      commit();
      wait_done(n);
      chk("lat_k6", 64'(n), 64'd1);

      // Stalled write across a pending commit.
      wait_fc(1);
      commit();
      wr_valid = 1'b1;
      wr_sel   = 2'd0;
      wr_ch    = 3'd5;
      wr_data  = 5'd4;
      chk("stall_ready", 64'(wr_ready), 64'd0);
      wait_done(n);
      chk("stall_absent", 64'(w_cos_1[5]), 64'd15);
      chk("stall_ready_back", 64'(wr_ready), 64'd1);
      step();
      wr_valid = 1'b0;
      commit();
      wait_done(n);
      chk("stall_landed", 64'(w_cos_1[5]), 64'd4);

      // Write in the same cycle as commit, then broadcast.
      wr_valid   = 1'b1;
      wr_sel     = 2'd2;
      wr_ch      = 3'd0;
      wr_data    = 5'd9;
      commit_req = 1'b1;
      step();
      wr_valid   = 1'b0;
      commit_req = 1'b0;
      wait_done(n);
      chk("same_cycle", 64'(w_cos_2[0]), 64'd9);
      wr(2'd0, 3'd6, 1'b1, 5'b10000);
      commit();
      wait_done(n);
      chk("bcast", 64'(w_cos_1), 64'({8{5'b10000}}));

      // Reset while pending.
      wr(2'd3, 3'd1, 1'b0, 5'd3);
      wait_fc(1);
      commit();
      wait_fc(4);
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      chk("rstp_busy", 64'(busy), 64'd0);
      chk("rstp_sin_2", 64'(w_sin_2), 64'd0);
      chk("rstp_cos_1", 64'(w_cos_1), 64'({8{5'd15}}));
      repeat (12) step();
      commit();
      wait_done(n);
      chk("rstp_shadow", 64'(w_sin_2), 64'd0);
      chk("rstp_shadow_c", 64'(w_cos_2), 64'({8{5'd15}}));

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         wr_valid   = ($urandom_range(0, 1) == 1);
         wr_sel     = 2'($urandom_range(0, 3));
         wr_ch      = 3'($urandom_range(0, 7));
         wr_bcast   = ($urandom_range(0, 6) == 0);
         wr_data    = 5'($urandom_range(0, 31));
         commit_req = ($urandom_range(0, 9) == 0);
         reset      = ($urandom_range(0, 63) == 0);
         step();
      end
      reset      = 1'b0;
      wr_valid   = 1'b0;
      commit_req = 1'b0;
      step();
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
